// File: rtl/kbd_pkg.sv
// kbd_pkg
//   Shared definitions for the keyboard-to-ASCII path:
//   - set-2 scan codes that need special handling (modifiers, whitespace keys)
//   - the "no character" ASCII value
//   - the captured keyboard event record
//   - a helper that classifies modifier scan codes
package kbd_pkg;

    // Modifier scan codes (set 2)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Whitespace / control scan codes (set 2)
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_TAB    = 8'h0D;

    // Translation result meaning "nothing to store"
    localparam logic [7:0] ASC_NONE  = 8'h00;

    // One keyboard event as captured on the strobe's rising edge
    typedef struct packed {
        logic [7:0] code;   // scan code
        logic       brk;    // 1 = break (key released), 0 = make
    } kbd_evt_t;

    // Shift and Caps Lock only change translation state; they never
    // produce a character themselves.
    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) || (code == SC_CAPS);
    endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// kbd_scan2ascii
//   Purely combinational US set-2 scan code to ASCII table.
//   Ports:
//     code  [7:0]  in   make scan code
//     upper        in   either Shift key held
//     caps         in   Caps Lock active
//     ascii [7:0]  out  translated character, ASC_NONE for unmapped codes
//   Letters are uppercase when (upper XOR caps). Digits take their shifted
//   symbol from upper only. Space/Enter/Backspace/Tab ignore both modifiers.
module kbd_scan2ascii
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        base   = ASC_NONE;
        letter = 1'b0;
        case (code)
            // letters: base is the lowercase code
            8'h1C: begin base = 8'h61; letter = 1'b1; end // a
            8'h32: begin base = 8'h62; letter = 1'b1; end // b
            8'h21: begin base = 8'h63; letter = 1'b1; end // c
            8'h23: begin base = 8'h64; letter = 1'b1; end // d
            8'h24: begin base = 8'h65; letter = 1'b1; end // e
            8'h2B: begin base = 8'h66; letter = 1'b1; end // f
            8'h34: begin base = 8'h67; letter = 1'b1; end // g
            8'h33: begin base = 8'h68; letter = 1'b1; end // h
            8'h43: begin base = 8'h69; letter = 1'b1; end // i
            8'h3B: begin base = 8'h6A; letter = 1'b1; end // j
            8'h42: begin base = 8'h6B; letter = 1'b1; end // k
            8'h4B: begin base = 8'h6C; letter = 1'b1; end // l
            8'h3A: begin base = 8'h6D; letter = 1'b1; end // m
            8'h31: begin base = 8'h6E; letter = 1'b1; end // n
            8'h44: begin base = 8'h6F; letter = 1'b1; end // o
            8'h4D: begin base = 8'h70; letter = 1'b1; end // p
            8'h15: begin base = 8'h71; letter = 1'b1; end // q
            8'h2D: begin base = 8'h72; letter = 1'b1; end // r
            8'h1B: begin base = 8'h73; letter = 1'b1; end // s
            8'h2C: begin base = 8'h74; letter = 1'b1; end // t
            8'h3C: begin base = 8'h75; letter = 1'b1; end // u
            8'h2A: begin base = 8'h76; letter = 1'b1; end // v
            8'h1D: begin base = 8'h77; letter = 1'b1; end // w
            8'h22: begin base = 8'h78; letter = 1'b1; end // x
            8'h35: begin base = 8'h79; letter = 1'b1; end // y
            8'h1A: begin base = 8'h7A; letter = 1'b1; end // z

            // digit row: shifted symbols follow the US layout
            8'h16: base = upper ? 8'h21 : 8'h31; // ! 1
            8'h1E: base = upper ? 8'h40 : 8'h32; // @ 2
            8'h26: base = upper ? 8'h23 : 8'h33; // # 3
            8'h25: base = upper ? 8'h24 : 8'h34; // $ 4
            8'h2E: base = upper ? 8'h25 : 8'h35; // % 5
            8'h36: base = upper ? 8'h5E : 8'h36; // ^ 6
            8'h3D: base = upper ? 8'h26 : 8'h37; // & 7
            8'h3E: base = upper ? 8'h2A : 8'h38; // * 8
            8'h46: base = upper ? 8'h28 : 8'h39; // ( 9
            8'h45: base = upper ? 8'h29 : 8'h30; // ) 0

            // whitespace / control keys
            SC_SPACE: base = 8'h20;
            SC_ENTER: base = 8'h0D;
            SC_BKSP:  base = 8'h08;
            SC_TAB:   base = 8'h09;

            default:  base = ASC_NONE;
        endcase
    end

    // Lowercase and uppercase ASCII letters differ only in bit 5.
    assign ascii = (letter && (upper ^ caps)) ? (base & 8'hDF) : base;

endmodule

// File: rtl/kbd_ascii_fifo.sv
// kbd_ascii_fifo
//   Consumes the scan-code event stream of a PS/2 keyboard interface, tracks
//   Shift / Caps Lock, translates make codes to ASCII and queues the
//   characters in a FIFO for the CPU.
//
//   Pipeline:
//     stage 0  rising edge of key_strobe captures key_code / key_release
//     stage 1  modifier update, translation, FIFO push (written at the end
//              of the stage-1 cycle)
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     key_code [7:0]      scan code from the keyboard interface
//     key_strobe          event strobe, only its rising edge counts
//     key_release         1 = break event, sampled with key_code
//     rd_en               CPU pop request, ignored while empty
//     rd_data [7:0]       character at the FIFO head (0 while empty)
//     rd_valid            FIFO not empty
//     count [AW:0]        occupancy
//     overflow            sticky: a character was dropped on a full FIFO
//     ovf_clr             clears overflow (a simultaneous new drop wins)
//     irq                 same as rd_valid
//
//   Build option:
//     KBD_TYPEMATIC_FILTER_EN  when defined, a repeated make of the most
//                              recent key (no break in between) is dropped,
//                              suppressing keyboard auto-repeat.
module kbd_ascii_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)   // derived, leave at default
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    key_code,
    input  logic          key_strobe,
    input  logic          key_release,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          irq
);

    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("kbd_ascii_fifo: DEPTH must be a power of two in 2..256");
    end

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Stage 0: strobe edge detect and event capture
    // ------------------------------------------------------------------
    logic     strobe_q_reg;
    logic     ev_valid_reg;
    kbd_evt_t ev_reg;
    logic     key_event;

    assign key_event = key_strobe & ~strobe_q_reg;

    // strobe_q resets to 1 so a strobe already high when reset releases is
    // treated as stale, not as a fresh key event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q_reg <= 1'b1;
            ev_valid_reg <= 1'b0;
            ev_reg       <= '0;
        end else begin
            strobe_q_reg <= key_strobe;
            ev_valid_reg <= key_event;
            if (key_event) begin
                ev_reg.code <= key_code;
                ev_reg.brk  <= key_release;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: modifiers and translation
    // ------------------------------------------------------------------
    logic       shift_l_reg;
    logic       shift_r_reg;
    logic       caps_reg;
    logic       ev_is_mod;
    logic [7:0] xlat_ascii;
    logic       repeat_hit;
    logic       push_req;

    assign ev_is_mod = is_modifier(ev_reg.code);

    kbd_scan2ascii u_scan2ascii (
        .code  (ev_reg.code),
        .upper (shift_l_reg | shift_r_reg),
        .caps  (caps_reg),
        .ascii (xlat_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l_reg <= 1'b0;
            shift_r_reg <= 1'b0;
            caps_reg    <= 1'b0;
        end else if (ev_valid_reg) begin
            case (ev_reg.code)
                SC_LSHIFT: shift_l_reg <= ~ev_reg.brk;
                SC_RSHIFT: shift_r_reg <= ~ev_reg.brk;
                // Caps Lock toggles on press only; its release is a no-op.
                SC_CAPS:   if (!ev_reg.brk) caps_reg <= ~caps_reg;
                default:   ;
            endcase
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    // last_make remembers the key currently held down (non-modifier).
    // A make matching it is an auto-repeat; its break re-arms the key.
    logic [7:0] last_make_reg;

    assign repeat_hit = ~ev_reg.brk && (ev_reg.code == last_make_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_make_reg <= 8'h00;
        end else if (ev_valid_reg && !ev_is_mod) begin
            if (!ev_reg.brk) begin
                last_make_reg <= ev_reg.code;
            end else if (ev_reg.code == last_make_reg) begin
                last_make_reg <= 8'h00;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign push_req = ev_valid_reg & ~ev_reg.brk & ~ev_is_mod &
                      (xlat_ascii != ASC_NONE) & ~repeat_hit;

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_ok;
    logic          push_ok;
    logic          ovf_set;

    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign pop_ok     = rd_en & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign push_ok    = push_req & (~fifo_full | pop_ok);
    assign ovf_set    = push_req & fifo_full & ~pop_ok;

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= xlat_ascii;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + AW'(1);
            if (pop_ok)  rptr_reg <= rptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (ovf_set) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid = ~fifo_empty;
    assign irq      = rd_valid;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    // Masked while empty so stale or uninitialised storage is never shown.
    assign rd_data  = rd_valid ? mem[rptr_reg] : ASC_NONE;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
module tb_kbd_ascii_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    key_code;
    logic          key_strobe;
    logic          key_release;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;
    logic          irq;

    kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .key_release (key_release),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       drain = 1'b0;
    logic [7:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    // Monitor: whenever draining and the DUT presents data, compare the head
    // against the scoreboard and pop it.
    always @(negedge clk) begin
        #1;
        rd_en = 1'b0;
        if (drain && rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected got=%02h want=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
            rd_en = 1'b1;
        end
    end

    // One key event: strobe high for one cycle, low for one cycle.
    task automatic send_key(input logic [7:0] code, input logic brk);
        @(negedge clk);
        key_code    = code;
        key_release = brk;
        key_strobe  = 1'b1;
        @(negedge clk);
        key_strobe  = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int n;
        drain = 1'b1;
        n = 0;
        while (n < 200 && !(count == 0 && exp_q.size() == 0)) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({name, "_count"}, {27'd0, count}, 32'd0);
        chk({name, "_sb_left"}, exp_q.size(), 32'd0);
        @(negedge clk);
        drain = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        key_code    = 8'h1C;
        key_strobe  = 1'b1;   // held across reset release
        key_release = 1'b0;
        rd_en       = 1'b0;
        ovf_clr     = 1'b0;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_count",    {27'd0, count},    32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_irq",      {31'd0, irq},      32'd0);
        chk("rst_rd_data",  {24'd0, rd_data},  32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_strobe_no_event", {27'd0, count}, 32'd0);
        key_strobe = 1'b0;
        settle();

        // ---- latency: 'a' visible two edges after the sampling edge
        @(negedge clk);
        key_code = 8'h1C; key_release = 1'b0; key_strobe = 1'b1;
        exp_q.push_back(8'h61);
        @(posedge clk); #1;
        chk("lat_edge1_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        key_strobe = 1'b0;
        @(posedge clk); #1;
        chk("lat_edge2_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("lat_rd_data", {24'd0, rd_data}, 32'h61);
        chk("lat_irq", {31'd0, irq}, 32'd1);
        chk("lat_count", {27'd0, count}, 32'd1);
        wait_empty("pop_a");
        chk("after_pop_rd_valid", {31'd0, rd_valid}, 32'd0);

        // ---- shifted digit, then unshifted
        drain = 1'b1;
        send_key(8'h12, 1'b0);
        send_key(8'h16, 1'b0); exp_q.push_back(8'h21);
        send_key(8'h12, 1'b1);
        send_key(8'h16, 1'b0); exp_q.push_back(8'h31);
        wait_empty("digits");

        // ---- caps XOR shift
        drain = 1'b1;
        send_key(8'h58, 1'b0);
        send_key(8'h58, 1'b1);
        send_key(8'h1C, 1'b0); exp_q.push_back(8'h41);
        send_key(8'h12, 1'b0);
        send_key(8'h1C, 1'b0); exp_q.push_back(8'h61);
        // specials unaffected by caps+shift, shifted '0'
        send_key(8'h5A, 1'b0); exp_q.push_back(8'h0D);
        send_key(8'h66, 1'b0); exp_q.push_back(8'h08);
        send_key(8'h0D, 1'b0); exp_q.push_back(8'h09);
        send_key(8'h45, 1'b0); exp_q.push_back(8'h29);
        send_key(8'h12, 1'b1);
        send_key(8'h58, 1'b0);
        send_key(8'h58, 1'b1);
        // right shift survives left shift release
        send_key(8'h12, 1'b0);
        send_key(8'h59, 1'b0);
        send_key(8'h12, 1'b1);
        send_key(8'h1A, 1'b0); exp_q.push_back(8'h5A);
        send_key(8'h59, 1'b1);
        send_key(8'h1A, 1'b0); exp_q.push_back(8'h7A);
        send_key(8'h07, 1'b0);              // unmapped: nothing
        wait_empty("mods");

        // ---- strobe held 5 cycles: one space; its break: nothing
        drain = 1'b1;
        @(negedge clk);
        key_code = 8'h29; key_release = 1'b0; key_strobe = 1'b1;
        exp_q.push_back(8'h20);
        repeat (5) @(negedge clk);
        key_strobe = 1'b0;
        send_key(8'h29, 1'b1);
        settle();
        wait_empty("held_space");

        // ---- typematic repeats
        send_key(8'h1C, 1'b0); exp_q.push_back(8'h61);
        send_key(8'h1C, 1'b0);
        send_key(8'h1C, 1'b0);
`ifndef KBD_TYPEMATIC_FILTER_EN
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h61);
`endif
        send_key(8'h1C, 1'b1);
        send_key(8'h1C, 1'b0); exp_q.push_back(8'h61);
        settle();
`ifdef KBD_TYPEMATIC_FILTER_EN
        chk("typematic_count", {27'd0, count}, 32'd2);
`else
        chk("typematic_count", {27'd0, count}, 32'd4);
`endif
        wait_empty("typematic");

        // ---- fill, overflow, push+pop when full, clear
        for (int i = 0; i < DEPTH; i++) begin
            send_key(8'h1C, 1'b0); exp_q.push_back(8'h61);
            send_key(8'h1C, 1'b1);
        end
        settle();
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        send_key(8'h1C, 1'b0);              // 17th: dropped
        send_key(8'h1C, 1'b1);
        settle();
        chk("ovf_count", {27'd0, count}, 32'd16);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        // push and pop land on the same edge
        @(negedge clk);
        key_code = 8'h32; key_release = 1'b0; key_strobe = 1'b1;
        exp_q.push_back(8'h62);
        @(negedge clk);
        key_strobe = 1'b0;
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        settle();
        chk("pushpop_count", {27'd0, count}, 32'd16);
        chk("pushpop_ovf", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        wait_empty("full_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
